// File: rtl/pipeline_stage_reg_if.sv
// rtl/pipeline_stage_reg_if.sv - valid/ready/data handshake bundle for pipeline_stage_reg
interface pipeline_stage_reg_if #(
   parameter int WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   // Producer side of a link: drives valid/data, observes ready
   modport master (
      output valid,
      output data,
      input  ready
   );

   // Consumer side of a link: observes valid/data, drives ready
   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - RV32I pipeline stage register with valid/ready, flush and optional skid entry
module pipeline_stage_reg #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] NOP_VALUE = 32'h00000013,
   parameter bit          SKID      = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   pipeline_stage_reg_if.slave    in_if,
   pipeline_stage_reg_if.master   out_if,
   output logic [1:0]             occupancy
);

   // State encoding doubles as the entry count, so occupancy is the state register itself.
   localparam logic [1:0] ST_EMPTY     = 2'd0;
   localparam logic [1:0] ST_FULL      = 2'd1;
   localparam logic [1:0] ST_SKID_FULL = 2'd2;

   // Bubble value, zero-extended or truncated to the payload width.
   localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_accept;
   logic             w_consume;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_accept    = in_if.valid & w_in_ready;
   assign w_consume   = w_out_valid & out_if.ready;

   // out_data comes straight from the main register, which holds the bubble value when empty.
   assign out_if.valid = w_out_valid;
   assign out_if.data  = r_main;
   assign in_if.ready  = w_in_ready;
   assign occupancy    = r_state;

   generate
      if (SKID) begin : gen_skid
         logic r_in_ready;

         // Registered ready: low exactly while both entries are occupied, no out_ready path.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_in_ready <= 1'b1;
            end else begin
               r_in_ready <= (w_state_nxt != ST_SKID_FULL);
            end
         end

         assign w_in_ready = r_in_ready;
      end else begin : gen_noskid
         assign w_in_ready = ~w_out_valid | out_if.ready;
      end
   endgenerate

   // Next-state and payload steering; in_data is only selected when a word is accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = NOP_W;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_main_nxt  = in_if.data;
               end
            end
            ST_FULL: begin
               // Without a skid entry an accept while full implies a consume in the same cycle.
               if (w_accept && (w_consume || !SKID)) begin
                  w_main_nxt = in_if.data;
               end else if (w_consume) begin
                  w_state_nxt = ST_EMPTY;
                  w_main_nxt  = NOP_W;
               end else if (w_accept) begin
                  w_state_nxt = ST_SKID_FULL;
                  w_skid_nxt  = in_if.data;
               end
            end
            ST_SKID_FULL: begin
               if (w_consume) begin
                  w_state_nxt = ST_FULL;
                  w_main_nxt  = r_skid;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_main_nxt  = NOP_W;
            end
         endcase
      end
   end

   // State and payload registers; reset drops every held entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_main  <= NOP_W;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

endmodule
